// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Inter-stage pipeline register with valid/ready handshake,
//                optional 2-entry skid buffer, flush-to-NOP and a saturating
//                downstream bubble counter.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int              DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter bit              SKID    = 1'b1,
  parameter int              CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Registered state. ready_q is the registered image of reset release, so
  // in_ready stays low while in reset and rises on the first edge after it.
  logic              ready_q;
  logic              main_v;
  logic [DATA_W-1:0] main_d;
  logic              skid_v;
  logic [DATA_W-1:0] skid_d;

  logic              main_v_nxt;
  logic [DATA_W-1:0] main_d_nxt;
  logic              skid_v_nxt;
  logic [DATA_W-1:0] skid_d_nxt;

  logic              accept;
  logic              issue;

  assign out_valid = main_v;
  assign out_data  = main_d;
  assign accept    = in_valid & in_ready;
  assign issue     = main_v & out_ready;

  // In skid mode in_ready depends only on registers; otherwise it follows
  // out_ready combinationally so a full entry can be replaced every cycle.
  if (SKID) begin : g_skid_ready
    assign in_ready = ready_q & ~skid_v;
  end else begin : g_single_ready
    assign in_ready = ready_q & (~main_v | out_ready);
  end

  // Next-state for the main and skid entries; flush wins over everything and
  // an empty entry always carries NOP_VAL.
  always_comb begin
    main_v_nxt = main_v;
    main_d_nxt = main_d;
    skid_v_nxt = skid_v;
    skid_d_nxt = skid_d;
    if (flush) begin
      main_v_nxt = 1'b0;
      main_d_nxt = NOP_VAL;
      skid_v_nxt = 1'b0;
      skid_d_nxt = NOP_VAL;
    end else if (SKID) begin
      if (skid_v) begin
        // in_ready is low here, so only the skid-to-main move can occur.
        if (issue) begin
          main_d_nxt = skid_d;
          skid_v_nxt = 1'b0;
          skid_d_nxt = NOP_VAL;
        end
      end else if (!main_v) begin
        if (accept) begin
          main_v_nxt = 1'b1;
          main_d_nxt = in_data;
        end
      end else if (issue) begin
        if (accept) begin
          main_d_nxt = in_data;
        end else begin
          main_v_nxt = 1'b0;
          main_d_nxt = NOP_VAL;
        end
      end else if (accept) begin
        skid_v_nxt = 1'b1;
        skid_d_nxt = in_data;
      end
    end else begin
      if (accept) begin
        main_v_nxt = 1'b1;
        main_d_nxt = in_data;
      end else if (issue) begin
        main_v_nxt = 1'b0;
        main_d_nxt = NOP_VAL;
      end
    end
  end

  // Entry registers and registered occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q   <= 1'b0;
      main_v    <= 1'b0;
      main_d    <= NOP_VAL;
      skid_v    <= 1'b0;
      skid_d    <= NOP_VAL;
      occupancy <= 2'd0;
    end else begin
      ready_q   <= 1'b1;
      main_v    <= main_v_nxt;
      main_d    <= main_d_nxt;
      skid_v    <= skid_v_nxt;
      skid_d    <= skid_d_nxt;
      occupancy <= {1'b0, main_v_nxt} + {1'b0, skid_v_nxt};
    end
  end

  // Saturating count of cycles where downstream was ready but got nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (out_ready && !main_v && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Directed table-driven bench for pipe_stage_reg, covering the
//                skid (instance A) and single-entry (instance B) variants.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP_A = 32'h0000_0013;

  logic clk;

  // Instance A: SKID=1, 32-bit payload, 3-bit bubble counter, NOP = 0x13
  logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic [2:0]  a_bc;

  // Instance B: SKID=0, 8-bit payload, default 16-bit counter, NOP = 0
  logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data, b_out_data;
  logic [1:0]  b_occ;
  logic [15:0] b_bc;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(32), .NOP_VAL(NOP_A), .SKID(1'b1), .CNT_W(3)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .bubble_cnt(a_bc)
  );

  pipe_stage_reg #(.DATA_W(8), .NOP_VAL(8'h00), .SKID(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .bubble_cnt(b_bc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  occ;
    logic [15:0] bc;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [31:0] id, input logic ordy,
                              input logic ir, input logic ov,
                              input logic [31:0] od, input logic [1:0] occ,
                              input logic [15:0] bc);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.od = od; v.occ = occ; v.bc = bc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector on the falling edge, compare outputs 1 time unit later.
  task automatic run_vec(input vec_t v, input bit sel_b, input int idx);
    string p;
    @(negedge clk);
    if (!sel_b) begin
      a_rst = v.rst; a_flush = v.flush; a_in_valid = v.iv;
      a_in_data = v.id; a_out_ready = v.ordy;
    end else begin
      b_rst = v.rst; b_flush = v.flush; b_in_valid = v.iv;
      b_in_data = v.id[7:0]; b_out_ready = v.ordy;
    end
    #1;
    p = sel_b ? $sformatf("B[%0d]", idx) : $sformatf("A[%0d]", idx);
    if (!sel_b) begin
      check({p, ".in_ready"},  32'(a_in_ready),  32'(v.ir));
      check({p, ".out_valid"}, 32'(a_out_valid), 32'(v.ov));
      check({p, ".out_data"},  a_out_data,       v.od);
      check({p, ".occupancy"}, 32'(a_occ),       32'(v.occ));
      check({p, ".bubble"},    32'(a_bc),        32'(v.bc));
    end else begin
      check({p, ".in_ready"},  32'(b_in_ready),  32'(v.ir));
      check({p, ".out_valid"}, 32'(b_out_valid), 32'(v.ov));
      check({p, ".out_data"},  32'(b_out_data),  v.od);
      check({p, ".occupancy"}, 32'(b_occ),       32'(v.occ));
      check({p, ".bubble"},    32'(b_bc),        32'(v.bc));
    end
  endtask

  initial begin
    a_rst = 0; a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_rst = 0; b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;

    // ---------------- instance A table (SKID=1) ----------------
    // fields: rst flush iv id ordy | in_ready out_valid out_data occ bubble
    for (int i = 0; i < 3; i++) va.push_back(mk(0,0,0,0,1, 0,0,NOP_A,0,0));
    va.push_back(mk(1,0,0,0,1, 0,0,NOP_A,0,0));
    for (int i = 1; i <= 4; i++) va.push_back(mk(1,0,0,0,1, 1,0,NOP_A,0,16'(i)));
    // streaming 1..8
    va.push_back(mk(1,0,1,1,1, 1,0,NOP_A,0,5));
    for (int k = 2; k <= 8; k++) va.push_back(mk(1,0,1,32'(k),1, 1,1,32'(k-1),1,6));
    va.push_back(mk(1,0,0,0,1, 1,1,8,1,6));
    va.push_back(mk(1,0,0,0,1, 1,0,NOP_A,0,6));
    // backpressure A0/A1/A2
    va.push_back(mk(1,0,1,32'hA0,1, 1,0,NOP_A,0,7));
    va.push_back(mk(1,0,1,32'hA1,0, 1,1,32'hA0,1,7));
    for (int i = 0; i < 3; i++) va.push_back(mk(1,0,1,32'hA2,0, 0,1,32'hA0,2,7));
    va.push_back(mk(1,0,1,32'hA2,1, 0,1,32'hA0,2,7));
    va.push_back(mk(1,0,1,32'hA2,1, 1,1,32'hA1,1,7));
    va.push_back(mk(1,0,0,0,1,      1,1,32'hA2,1,7));
    // flush with 0x11 in main, 0x22 in skid, 0x33 offered
    va.push_back(mk(1,0,1,32'h11,0, 1,0,NOP_A,0,7));
    va.push_back(mk(1,0,1,32'h22,0, 1,1,32'h11,1,7));
    va.push_back(mk(1,1,1,32'h33,0, 0,1,32'h11,2,7));
    va.push_back(mk(1,0,0,0,0,      1,0,NOP_A,0,7));
    va.push_back(mk(1,1,1,32'h33,1, 1,0,NOP_A,0,7));
    va.push_back(mk(1,0,0,0,1,      1,0,NOP_A,0,7));
    va.push_back(mk(1,0,0,0,0,      1,0,NOP_A,0,7));

    // ---------------- instance B table (SKID=0) ----------------
    for (int i = 0; i < 2; i++) vb.push_back(mk(0,0,0,0,1, 0,0,0,0,0));
    vb.push_back(mk(1,0,0,0,1,     0,0,0,0,0));
    vb.push_back(mk(1,0,1,8'hA0,1, 1,0,0,0,1));
    for (int i = 0; i < 4; i++) vb.push_back(mk(1,0,1,8'hA1,0, 0,1,8'hA0,1,2));
    vb.push_back(mk(1,0,1,8'hA1,1, 1,1,8'hA0,1,2));
    vb.push_back(mk(1,0,1,8'hA2,1, 1,1,8'hA1,1,2));
    vb.push_back(mk(1,0,0,0,1,     1,1,8'hA2,1,2));
    vb.push_back(mk(1,0,0,0,0,     1,0,0,0,2));
    vb.push_back(mk(1,1,1,8'hC5,1, 1,0,0,0,2));
    vb.push_back(mk(1,0,0,0,0,     1,0,0,0,3));

    foreach (va[i]) run_vec(va[i], 1'b0, i);

    // A: counter saturation after a fresh reset
    @(negedge clk);
    a_rst = 0; a_in_valid = 0; a_out_ready = 0;
    #1;
    check("A.sat_reset_bubble", 32'(a_bc), 32'd0);
    @(negedge clk);
    a_rst = 1; a_out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("A.sat_bubble[%0d]", i), 32'(a_bc), (i > 7) ? 32'd7 : 32'(i));
    end

    // A: fill both entries, then async reset between edges
    @(negedge clk);
    a_out_ready = 0; a_in_valid = 1; a_in_data = 32'hB0;
    @(negedge clk);
    a_in_data = 32'hB1;
    @(negedge clk);
    a_in_valid = 0;
    @(posedge clk);
    #3;
    check("A.pre_rst_occ",    32'(a_occ), 32'd2);
    check("A.pre_rst_data",   a_out_data, 32'hB0);
    a_rst = 0;
    #1;
    check("A.arst_out_valid", 32'(a_out_valid), 32'd0);
    check("A.arst_occ",       32'(a_occ),       32'd0);
    check("A.arst_bubble",    32'(a_bc),        32'd0);
    check("A.arst_out_data",  a_out_data,       NOP_A);
    check("A.arst_in_ready",  32'(a_in_ready),  32'd0);

    foreach (vb[i]) run_vec(vb[i], 1'b1, i);

    // B: in_ready follows out_ready within a cycle while main is full
    @(negedge clk);
    b_in_valid = 1; b_in_data = 8'h5A; b_out_ready = 0;
    @(negedge clk);
    b_in_valid = 0;
    #1;
    check("B.comb_ready_lo",  32'(b_in_ready), 32'd0);
    b_out_ready = 1;
    #1;
    check("B.comb_ready_hi",  32'(b_in_ready), 32'd1);
    b_out_ready = 0;
    #1;
    check("B.comb_ready_lo2", 32'(b_in_ready), 32'd0);
    check("B.held_data",      32'(b_out_data), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
